// File: rtl/max_pool_layer.sv
// max_pool_layer: streaming 2x2 / stride-2 max pool with argmax index.
// Samples arrive in raster order, one per accepted beat. Even rows reduce
// each horizontal pair into a half-row line buffer; odd rows reduce their
// pair and compare it against the buffered top pair to form the window result.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data is a signed sample
//   out_valid/out_ready output handshake; out_data = window max,
//                       out_idx = argmax (0=TL 1=TR 2=BL 3=BR)
//   frame_done          high in the cycle the last window of a frame is taken
module max_pool_layer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned IN_HEIGHT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             frame_done
);

    localparam int unsigned CW  = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int unsigned RW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int unsigned LBN = IN_WIDTH / 2;
    localparam int unsigned LW  = (LBN > 1) ? $clog2(LBN) : 1;

    typedef enum logic {
        ST_TOP = 1'b0,
        ST_BOT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_lb_data [LBN];
    logic             r_lb_idx  [LBN];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_idx;
    logic             r_out_last;

    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic [LW-1:0]    w_lb_addr;
    logic             w_pair_gt;
    logic [WIDTH-1:0] w_pair_max;
    logic             w_bot_gt;

    // A stalled result blocks new input; a consumed one frees the slot this cycle.
    assign in_ready   = !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == CW'(IN_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IN_HEIGHT - 1));
    assign w_lb_addr  = LW'(r_col >> 1);

    // Later sample wins only when strictly greater, so ties keep the earlier one.
    assign w_pair_gt  = $signed(in_data) > $signed(r_hold);
    assign w_pair_max = w_pair_gt ? in_data : r_hold;
    assign w_bot_gt   = $signed(w_pair_max) > $signed(r_lb_data[w_lb_addr]);

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign frame_done = r_out_valid && out_ready && r_out_last;

    // Line buffer: top-pair max and which column of the pair it came from.
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == ST_TOP) && r_col[0]) begin
            r_lb_data[w_lb_addr] <= w_pair_max;
            r_lb_idx[w_lb_addr]  <= w_pair_gt;
        end
    end

    // Position counters, row-parity FSM and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_TOP;
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end

                if (!r_col[0]) begin
                    r_hold <= in_data;
                end

                case (r_state)
                    ST_TOP: begin
                        if (w_col_last) begin
                            r_state <= ST_BOT;
                        end
                    end
                    ST_BOT: begin
                        if (r_col[0]) begin
                            // Bottom pair only displaces the top pair when strictly greater.
                            r_out_valid <= 1'b1;
                            r_out_last  <= w_row_last && w_col_last;
                            if (w_bot_gt) begin
                                r_out_data <= w_pair_max;
                                r_out_idx  <= {1'b1, w_pair_gt};
                            end else begin
                                r_out_data <= r_lb_data[w_lb_addr];
                                r_out_idx  <= {1'b0, r_lb_idx[w_lb_addr]};
                            end
                        end
                        if (w_col_last) begin
                            r_state <= ST_TOP;
                        end
                    end
                    default: r_state <= ST_TOP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max_pool_layer.sv
// tb_max_pool_layer: scoreboard bench for max_pool_layer (4x4, 16-bit).
// Expected windows are computed from each frame and queued before the frame
// is driven; a monitor pops and compares on every accepted output.
module tb_max_pool_layer;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  i;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        frame_done;

    exp_t        q[$];
    logic [15:0] frm [NPIX];
    int          n_vec = 0;
    int          n_err = 0;
    int          fd_cnt = 0;
    int          fd_exp = 0;
    int          stall_token = 0;
    logic        block_out = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        gaps = 1'b0;

    max_pool_layer #(.WIDTH(16), .IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: scan the four window positions in raster order, strict > only.
    task automatic push_expect();
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                exp_t e;
                int   base;
                base   = 2 * wr * W + 2 * wc;
                e.d    = frm[base];
                e.i    = 2'd0;
                for (int k = 1; k < 4; k++) begin
                    int pos;
                    pos = base + (k % 2) + (k / 2) * W;
                    if ($signed(frm[pos]) > $signed(e.d)) begin
                        e.d = frm[pos];
                        e.i = 2'(k);
                    end
                end
                e.last = (wr == H / 2 - 1) && (wc == W / 2 - 1);
                q.push_back(e);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send(input logic [15:0] v);
        int n;
        n = 0;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input int npix);
        for (int p = 0; p < npix; p++) send(frm[p]);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_drain"}, 32'(q.size()), 32'd0);
        check({tag, "_frame_done_count"}, 32'(fd_cnt), 32'(fd_exp));
    endtask

    // Output ready generator: forced stalls, random back-pressure or always ready.
    initial begin
        int stall_left;
        int last_tok;
        stall_left = 0;
        last_tok   = 0;
        out_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (block_out) begin
                out_ready = 1'b0;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (stall_token != last_tok && out_valid) begin
                out_ready  = 1'b0;
                stall_left = 4;
                last_tok   = stall_token;
            end else if (rnd_mode) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard compare on accept, stability and in_ready while stalled.
    initial begin
        logic        stalled;
        logic [15:0] held_d;
        logic [1:0]  held_i;
        stalled = 1'b0;
        held_d  = '0;
        held_i  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (frame_done) fd_cnt++;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.d));
                        check("out_idx", 32'(out_idx), 32'(e.i));
                        check("frame_done", 32'(frame_done), 32'(e.last));
                    end
                end else if (frame_done) begin
                    check("frame_done_stray", 32'd1, 32'd0);
                end
                if (out_valid && !out_ready) begin
                    check("in_ready_stall", 32'(in_ready), 32'd0);
                    if (stalled) begin
                        check("stall_data_stable", 32'(out_data), 32'(held_d));
                        check("stall_idx_stable", 32'(out_idx), 32'(held_i));
                    end
                    stalled = 1'b1;
                    held_d  = out_data;
                    held_i  = out_idx;
                end else begin
                    stalled = 1'b0;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Ramp 0..15: every window max is its BR sample.
        for (int p = 0; p < NPIX; p++) frm[p] = 16'(p);
        push_expect();
        send_frame(NPIX);
        fd_exp++;
        drain("ramp");

        // All -1: every window ties, TL must win.
        for (int p = 0; p < NPIX; p++) frm[p] = 16'hFFFF;
        push_expect();
        send_frame(NPIX);
        fd_exp++;
        drain("all_neg1");

        // First window TL=-8 TR=3 BL=3 BR=-2 -> 3 from TR.
        for (int p = 0; p < NPIX; p++) frm[p] = 16'($urandom);
        frm[0]     = 16'hFFF8;
        frm[1]     = 16'd3;
        frm[W]     = 16'd3;
        frm[W + 1] = 16'hFFFE;
        push_expect();
        send_frame(NPIX);
        fd_exp++;
        drain("window_tie");

        // Hold out_ready low five cycles after the first result.
        stall_token++;
        for (int p = 0; p < NPIX; p++) frm[p] = 16'($urandom);
        push_expect();
        send_frame(NPIX);
        fd_exp++;
        drain("stall");

        // Two frames back to back, in_valid never dropped between them.
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < NPIX; p++) frm[p] = 16'($urandom);
            push_expect();
            send_frame(NPIX);
            fd_exp++;
        end
        drain("back_to_back");

        // Random data with input gaps and output back-pressure.
        rnd_mode = 1'b1;
        gaps     = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < NPIX; p++) frm[p] = 16'($urandom_range(0, 15)) - 16'd8;
            push_expect();
            send_frame(NPIX);
            fd_exp++;
        end
        rnd_mode = 1'b0;
        gaps     = 1'b0;
        drain("random");

        // Reset after six beats with the first result still pending.
        block_out = 1'b1;
        repeat (2) @(negedge clk);
        for (int p = 0; p < NPIX; p++) frm[p] = 16'(100 + p);
        send_frame(6);
        in_valid = 1'b0;
        check("pre_reset_pending", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        reset     = 1'b0;
        block_out = 1'b0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < NPIX; p++) frm[p] = 16'(p);
        push_expect();
        send_frame(NPIX);
        fd_exp++;
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
